// File: rtl/ifm_row_loader.sv
// rtl/ifm_row_loader.sv - fetches one IFM row from memory into a rotating line-buffer slot
module ifm_row_loader #(
  parameter int W_SIZE    = 12,
  parameter int W_CHANNEL = 5,
  parameter int IFM_DW    = 32,
  parameter int BUF_AW    = 9,
  parameter int MEM_AW    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [MEM_AW-1:0]    q_base_addr,
  input  logic                 c_req_load,
  input  logic [W_SIZE-1:0]    c_req_row,
  output logic                 o_req_ready,
  output logic                 o_mem_req,
  output logic [MEM_AW-1:0]    o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic                 i_mem_rvalid,
  input  logic [IFM_DW-1:0]    i_mem_rdata,
  output logic [2:0]           o_ib_we,
  output logic [BUF_AW-1:0]    o_ib_addr,
  output logic [IFM_DW-1:0]    o_ib_wdata,
  output logic                 o_ib_done,
  output logic [1:0]           o_ib_done_slot,
  output logic                 o_busy
);

  localparam int W_N    = W_SIZE + W_CHANNEL;
  localparam int W_CNT  = BUF_AW + 1;
  localparam int W_PROD = W_SIZE + W_N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic              pend_q,      pend_d;
  logic [W_SIZE-1:0] pend_row_q,  pend_row_d;
  logic [1:0]        slot_q,      slot_d;
  logic [MEM_AW-1:0] addr_q,      addr_d;
  logic [W_CNT-1:0]  issue_cnt_q, issue_cnt_d;
  logic [W_CNT-1:0]  recv_cnt_q,  recv_cnt_d;
  logic [2:0]        we_q,        we_d;
  logic [BUF_AW-1:0] ib_addr_q,   ib_addr_d;
  logic [IFM_DW-1:0] wdata_q,     wdata_d;

  logic [W_N-1:0]    n_words;
  logic [W_N-1:0]    issue_ext;
  logic [W_N-1:0]    recv_ext;
  logic              accept;
  logic              start;
  logic [W_SIZE-1:0] start_row;
  logic [W_PROD-1:0] start_prod;
  logic [MEM_AW-1:0] start_addr;
  logic [1:0]        start_slot;
  logic              mem_req;
  logic              recv_en;

  // Row geometry, start address/slot of the row about to begin, and handshake qualifiers
  always_comb begin
    n_words    = W_N'(q_width) * W_N'(q_channel);
    issue_ext  = W_N'(issue_cnt_q);
    recv_ext   = W_N'(recv_cnt_q);
    accept     = c_req_load && !pend_q;
    // A pending request always wins in IDLE; ready is low then, so no new one can collide
    start_row  = pend_q ? pend_row_q : c_req_row;
    start      = (state_q == S_IDLE) && (pend_q || c_req_load);
    // Full-width product, then wrap into the memory address space
    start_prod = W_PROD'(start_row) * W_PROD'(n_words);
    start_addr = q_base_addr + MEM_AW'(start_prod);
    start_slot = 2'(start_row % W_SIZE'(3));
    mem_req    = (state_q == S_ISSUE) && (issue_ext < n_words);
    recv_en    = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && i_mem_rvalid &&
                 (recv_ext < n_words);
  end

  // Next-state logic: request capture, issue sequencing and the registered write path
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    slot_d      = slot_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    we_d        = 3'b000;
    ib_addr_d   = ib_addr_q;
    wdata_d     = wdata_q;

    if (state_q == S_IDLE) begin
      if (pend_q) pend_d = 1'b0;
    end else if (accept) begin
      pend_d     = 1'b1;
      pend_row_d = c_req_row;
    end

    if (recv_en) begin
      we_d       = 3'b001 << slot_q;
      ib_addr_d  = recv_cnt_q[BUF_AW-1:0];
      wdata_d    = i_mem_rdata;
      recv_cnt_d = recv_cnt_q + W_CNT'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          addr_d      = start_addr;
          slot_d      = start_slot;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (n_words == '0) begin
          state_d = S_DONE;
        end else if (mem_req && i_mem_ack) begin
          addr_d      = addr_q + MEM_AW'(1);
          issue_cnt_d = issue_cnt_q + W_CNT'(1);
          if (issue_ext + W_N'(1) == n_words) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (recv_ext == n_words) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any load in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pend_row_q  <= '0;
      slot_q      <= 2'd0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      we_q        <= 3'b000;
      ib_addr_q   <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_row_q  <= pend_row_d;
      slot_q      <= slot_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      we_q        <= we_d;
      ib_addr_q   <= ib_addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_req_ready    = !pend_q;
  assign o_mem_req      = mem_req;
  assign o_mem_addr     = addr_q;
  assign o_ib_we        = we_q;
  assign o_ib_addr      = ib_addr_q;
  assign o_ib_wdata     = wdata_q;
  assign o_ib_done      = (state_q == S_DONE);
  assign o_ib_done_slot = (state_q == S_DONE) ? slot_q : 2'd0;
  assign o_busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);

endmodule
